// File: rtl/ad_emu_pkg.sv
// Shared constants and types for the serial ADC emulator.
package ad_emu_pkg;

   localparam int unsigned FRAME_BITS_DEF = 16;
   localparam int unsigned WORD_W         = 16;
   localparam int unsigned CNT_W          = 8;

   // Left-shift Fibonacci taps for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
   localparam logic [WORD_W-1:0] LFSR_TAPS = 16'hB400;

   localparam logic [7:0] OFF_MODE     = 8'h00;
   localparam logic [7:0] OFF_CONST_LO = 8'h01;
   localparam logic [7:0] OFF_CONST_HI = 8'h02;
   localparam logic [7:0] OFF_STEP     = 8'h03;
   localparam logic [7:0] OFF_FCNT_LO  = 8'h04;
   localparam logic [7:0] OFF_FCNT_HI  = 8'h05;
   localparam logic [7:0] OFF_ACNT     = 8'h06;
   localparam logic [7:0] OFF_CTRL     = 8'h07;

   typedef enum logic [1:0] {
      MODE_CONST = 2'd0,
      MODE_RAMP  = 2'd1,
      MODE_LFSR  = 2'd2,
      MODE_ALT   = 2'd3
   } mode_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   // Programmable configuration held by the fx register block
   typedef struct packed {
      logic [1:0]        mode;
      logic [WORD_W-1:0] cval;
      logic [7:0]        step;
   } cfg_t;

   // One LFSR step: shift left, feedback is the parity of the tapped bits
   function automatic logic [WORD_W-1:0] lfsr_next(input logic [WORD_W-1:0] w);
      return {w[WORD_W-2:0], ^(w & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/ad_emu_gen.sv
// Pattern generator: constant, ramp or LFSR word, advanced once per completed frame.
module ad_emu_gen
   import ad_emu_pkg::*;
#(
   parameter logic [WORD_W-1:0] LFSR_SEED = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        i_mode,
   input  logic [WORD_W-1:0] i_const,
   input  logic [7:0]        i_step,
   input  logic              i_advance,
   output logic [WORD_W-1:0] o_word
);

   logic [1:0]        r_mode_q;
   logic [WORD_W-1:0] r_word;
   logic [WORD_W-1:0] w_seed;

   // A zero seed would lock the LFSR, so fall back to the built-in seed
   assign w_seed = (i_const == '0) ? LFSR_SEED : i_const;

   // Word register; reloads on entry to ramp/LFSR mode, tracks CONST otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode_q <= MODE_CONST;
         r_word   <= '0;
      end else begin
         r_mode_q <= i_mode;
         case (i_mode)
            MODE_RAMP: begin
               if (r_mode_q != MODE_RAMP)
                  r_word <= i_const;
               else if (i_advance)
                  r_word <= r_word + WORD_W'(i_step);
            end
            MODE_LFSR: begin
               if (r_mode_q != MODE_LFSR)
                  r_word <= w_seed;
               else if (i_advance)
                  r_word <= lfsr_next(r_word);
            end
            default: r_word <= i_const;
         endcase
      end
   end

   assign o_word = r_word;

endmodule

// File: rtl/ad_emu.sv
// Serial ADC emulator: answers cs_n/sclk frames with generated words, fx bus slave.
module ad_emu
   import ad_emu_pkg::*;
#(
   parameter int unsigned       FRAME_BITS = FRAME_BITS_DEF,
   parameter logic [WORD_W-1:0] LFSR_SEED  = 16'hACE1
) (
   input  logic        clk_sys,
   input  logic        rst_n,
   input  logic        cs_n,
   input  logic        sclk,
   output logic        sdata,
   output logic [15:0] tx_data,
   output logic        tx_vld,
   input  logic [21:0] fx_waddr,
   input  logic        fx_wr,
   input  logic [7:0]  fx_data,
   input  logic        fx_rd,
   input  logic [21:0] fx_raddr,
   output logic [7:0]  fx_q,
   input  logic [5:0]  dev_id
);

   logic [1:0]        r_cs_sync;
   logic [1:0]        r_sclk_sync;
   logic              r_cs_d;
   logic              r_sclk_d;
   logic              w_cs_fall;
   logic              w_cs_rise;
   logic              w_sclk_fall;
   logic              w_sclk_rise;

   state_e            r_state;
   state_e            w_state_nxt;
   logic              w_load;
   logic              w_shift;
   logic              w_count;
   logic              w_clear;
   logic              w_done;
   logic              w_abort;

   logic [WORD_W-1:0] r_shift;
   logic [WORD_W-1:0] r_sent;
   logic [CNT_W-1:0]  r_bit_cnt;
   logic [WORD_W-1:0] r_tx_data;
   logic              r_tx_vld;

   cfg_t              r_cfg;
   logic [15:0]       r_frame_cnt;
   logic [7:0]        r_abort_cnt;
   logic [7:0]        r_fx_q;
   logic [7:0]        w_rdata;
   logic              w_wsel;
   logic              w_rsel;
   logic              w_cnt_clr;
   logic [WORD_W-1:0] w_word;

   // Two-flop synchronisers plus one delay flop for edge detection
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         r_cs_sync   <= 2'b11;
         r_cs_d      <= 1'b1;
         r_sclk_sync <= 2'b00;
         r_sclk_d    <= 1'b0;
      end else begin
         r_cs_sync   <= {r_cs_sync[0], cs_n};
         r_cs_d      <= r_cs_sync[1];
         r_sclk_sync <= {r_sclk_sync[0], sclk};
         r_sclk_d    <= r_sclk_sync[1];
      end
   end

   assign w_cs_fall   =  r_cs_d   & ~r_cs_sync[1];
   assign w_cs_rise   = ~r_cs_d   &  r_cs_sync[1];
   assign w_sclk_fall =  r_sclk_d & ~r_sclk_sync[1];
   assign w_sclk_rise = ~r_sclk_d &  r_sclk_sync[1];

   // FSM state register
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state and datapath controls; a cs_n edge overrides any sclk edge
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_count     = 1'b0;
      w_clear     = 1'b0;
      w_done      = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_cs_fall) begin
               w_load      = 1'b1;
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (w_cs_rise) begin
               w_clear     = 1'b1;
               w_state_nxt = ST_IDLE;
               if (r_bit_cnt >= CNT_W'(FRAME_BITS)) w_done  = 1'b1;
               else                                  w_abort = 1'b1;
            end else begin
               w_count = w_sclk_rise;
               w_shift = w_sclk_fall;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Shift register and rising-edge counter; zeros fill in past the word
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         r_shift   <= '0;
         r_sent    <= '0;
         r_bit_cnt <= '0;
      end else if (w_load) begin
         r_shift   <= w_word;
         r_sent    <= w_word;
         r_bit_cnt <= '0;
      end else if (w_clear) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
      end else begin
         if (w_shift)
            r_shift <= {r_shift[WORD_W-2:0], 1'b0};
         if (w_count && (r_bit_cnt != '1))
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
   end

   assign sdata = r_shift[WORD_W-1];

   // Scoreboard tap: word of the last completed frame
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_data <= '0;
         r_tx_vld  <= 1'b0;
      end else begin
         r_tx_vld <= w_done;
         if (w_done) r_tx_data <= r_sent;
      end
   end

   assign tx_data = r_tx_data;
   assign tx_vld  = r_tx_vld;

   ad_emu_gen #(
      .LFSR_SEED (LFSR_SEED)
   ) u_gen (
      .clk       (clk_sys),
      .rst_n     (rst_n),
      .i_mode    (r_cfg.mode),
      .i_const   (r_cfg.cval),
      .i_step    (r_cfg.step),
      .i_advance (w_done),
      .o_word    (w_word)
   );

   assign w_wsel    = fx_wr && (fx_waddr[21:16] == dev_id) && (fx_waddr[15:8] == 8'h00);
   assign w_rsel    = fx_rd && (fx_raddr[21:16] == dev_id) && (fx_raddr[15:8] == 8'h00);
   assign w_cnt_clr = w_wsel && (fx_waddr[7:0] == OFF_CTRL) && fx_data[0];

   // Writable configuration registers
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         r_cfg.mode <= MODE_CONST;
         r_cfg.cval <= '0;
         r_cfg.step <= 8'd1;
      end else if (w_wsel) begin
         case (fx_waddr[7:0])
            OFF_MODE:     r_cfg.mode       <= fx_data[1:0];
            OFF_CONST_LO: r_cfg.cval[7:0]  <= fx_data;
            OFF_CONST_HI: r_cfg.cval[15:8] <= fx_data;
            OFF_STEP:     r_cfg.step       <= fx_data;
            default: ;
         endcase
      end
   end

   // Frame and abort counters; a clear beats a coincident increment
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_cnt <= '0;
         r_abort_cnt <= '0;
      end else if (w_cnt_clr) begin
         r_frame_cnt <= '0;
         r_abort_cnt <= '0;
      end else begin
         if (w_done)
            r_frame_cnt <= r_frame_cnt + 16'd1;
         if (w_abort && (r_abort_cnt != 8'hFF))
            r_abort_cnt <= r_abort_cnt + 8'd1;
      end
   end

   // Read mux; unmapped offsets return zero
   always_comb begin
      w_rdata = 8'h00;
      case (fx_raddr[7:0])
         OFF_MODE:     w_rdata = {6'd0, r_cfg.mode};
         OFF_CONST_LO: w_rdata = r_cfg.cval[7:0];
         OFF_CONST_HI: w_rdata = r_cfg.cval[15:8];
         OFF_STEP:     w_rdata = r_cfg.step;
         OFF_FCNT_LO:  w_rdata = r_frame_cnt[7:0];
         OFF_FCNT_HI:  w_rdata = r_frame_cnt[15:8];
         OFF_ACNT:     w_rdata = r_abort_cnt;
         default:      w_rdata = 8'h00;
      endcase
   end

   // Registered read data, zero whenever not selected so buses can OR-merge
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) r_fx_q <= 8'h00;
      else        r_fx_q <= w_rsel ? w_rdata : 8'h00;
   end

   assign fx_q = r_fx_q;

endmodule

// File: tb/tb_ad_emu.sv
// Self-checking bench for ad_emu: register table, directed frames, random frames vs model.
module tb_ad_emu;

   localparam logic [5:0] DEV = 6'h2A;
   localparam logic [5:0] OTH = 6'h15;

   logic        clk_sys = 1'b0;
   logic        rst_n   = 1'b0;
   logic        cs_n    = 1'b1;
   logic        sclk    = 1'b0;
   logic        sdata;
   logic [15:0] tx_data;
   logic        tx_vld;
   logic [21:0] fx_waddr = '0;
   logic        fx_wr    = 1'b0;
   logic [7:0]  fx_data  = '0;
   logic        fx_rd    = 1'b0;
   logic [21:0] fx_raddr = '0;
   logic [7:0]  fx_q;

   ad_emu dut (
      .clk_sys (clk_sys), .rst_n (rst_n), .cs_n (cs_n), .sclk (sclk),
      .sdata (sdata), .tx_data (tx_data), .tx_vld (tx_vld),
      .fx_waddr (fx_waddr), .fx_wr (fx_wr), .fx_data (fx_data),
      .fx_rd (fx_rd), .fx_raddr (fx_raddr), .fx_q (fx_q), .dev_id (DEV)
   );

   always #5 clk_sys = ~clk_sys;

   int n_chk  = 0;
   int n_pass = 0;

   // tx_vld monitor
   int          vld_cnt = 0;
   logic [15:0] last_tx = '0;
   always @(negedge clk_sys) begin
      if (tx_vld) begin
         vld_cnt = vld_cnt + 1;
         last_tx = tx_data;
      end
   end

   // Reference model state (register-level view of the emulator)
   logic [1:0]  m_mode;
   logic [15:0] m_const, m_word, m_fcnt;
   logic [7:0]  m_step, m_acnt;

   task automatic model_reset();
      m_mode = 0; m_const = 0; m_step = 8'd1; m_word = 0; m_fcnt = 0; m_acnt = 0;
   endtask

   function automatic logic [15:0] model_word();
      return (m_mode == 2'd1 || m_mode == 2'd2) ? m_word : m_const;
   endfunction

   // Polynomial x^16+x^14+x^13+x^11+1 written as a left-shifting Fibonacci register
   function automatic logic [15:0] poly_step(input logic [15:0] w);
      logic fb;
      fb = w[15] ^ w[13] ^ w[12] ^ w[10];
      return {w[14:0], fb};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (act === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   function automatic logic [21:0] ra(input logic [5:0] dev, input logic [7:0] off);
      return {dev, 8'h00, off};
   endfunction

   task automatic fx_write(input logic [21:0] addr, input logic [7:0] d);
      logic [1:0] nm;
      @(negedge clk_sys);
      fx_waddr = addr; fx_data = d; fx_wr = 1'b1;
      @(negedge clk_sys);
      fx_wr = 1'b0;
      if (addr[21:16] == DEV && addr[15:8] == 8'h00) begin
         case (addr[7:0])
            8'h00: begin
               nm = d[1:0];
               if (nm == 2'd1 && m_mode != 2'd1) m_word = m_const;
               if (nm == 2'd2 && m_mode != 2'd2) m_word = (m_const == 0) ? 16'hACE1 : m_const;
               m_mode = nm;
            end
            8'h01: m_const[7:0]  = d;
            8'h02: m_const[15:8] = d;
            8'h03: m_step = d;
            8'h07: if (d[0]) begin m_fcnt = 0; m_acnt = 0; end
            default: ;
         endcase
      end
   endtask

   task automatic fx_read(input logic [21:0] addr, output logic [7:0] q);
      @(negedge clk_sys);
      fx_raddr = addr; fx_rd = 1'b1;
      @(negedge clk_sys);
      fx_rd = 1'b0;
      q = fx_q;
   endtask

   // Master side of one frame: sample sdata as sclk rises, 5-cycle half periods
   task automatic xfer(input int nbits, output logic [31:0] rx, output int dv);
      int v0;
      v0 = vld_cnt;
      rx = '0;
      @(negedge clk_sys);
      cs_n = 1'b0;
      repeat (6) @(negedge clk_sys);
      for (int i = 0; i < nbits; i++) begin
         rx = {rx[30:0], sdata};
         sclk = 1'b1;
         repeat (5) @(negedge clk_sys);
         sclk = 1'b0;
         repeat (5) @(negedge clk_sys);
      end
      cs_n = 1'b1;
      repeat (8) @(negedge clk_sys);
      dv = vld_cnt - v0;
      if (nbits >= 16) begin
         m_fcnt = m_fcnt + 16'd1;
         if (m_mode == 2'd1) m_word = m_word + {8'h00, m_step};
         else if (m_mode == 2'd2) m_word = poly_step(m_word);
      end else if (m_acnt != 8'hFF) begin
         m_acnt = m_acnt + 8'd1;
      end
   endtask

   typedef struct {
      logic        is_rd;
      logic [21:0] addr;
      logic [7:0]  data;
      logic [7:0]  exp;
   } vec_t;

   vec_t        tbl[22];
   logic [7:0]  q;
   logic [31:0] rx;
   int          dv;
   int          nb;
   logic [15:0] ew;

   initial begin
      model_reset();
      tbl[0]  = '{1'b1, ra(DEV, 8'h00), 8'h00, 8'h00};
      tbl[1]  = '{1'b1, ra(DEV, 8'h01), 8'h00, 8'h00};
      tbl[2]  = '{1'b1, ra(DEV, 8'h02), 8'h00, 8'h00};
      tbl[3]  = '{1'b1, ra(DEV, 8'h03), 8'h00, 8'h01};
      tbl[4]  = '{1'b1, ra(DEV, 8'h04), 8'h00, 8'h00};
      tbl[5]  = '{1'b1, ra(DEV, 8'h05), 8'h00, 8'h00};
      tbl[6]  = '{1'b1, ra(DEV, 8'h06), 8'h00, 8'h00};
      tbl[7]  = '{1'b1, ra(DEV, 8'h07), 8'h00, 8'h00};
      tbl[8]  = '{1'b1, ra(DEV, 8'h09), 8'h00, 8'h00};
      tbl[9]  = '{1'b0, ra(DEV, 8'h03), 8'h37, 8'h00};
      tbl[10] = '{1'b1, ra(DEV, 8'h03), 8'h00, 8'h37};
      tbl[11] = '{1'b0, ra(OTH, 8'h03), 8'h99, 8'h00};
      tbl[12] = '{1'b1, ra(DEV, 8'h03), 8'h00, 8'h37};
      tbl[13] = '{1'b1, ra(OTH, 8'h03), 8'h00, 8'h00};
      tbl[14] = '{1'b0, ra(DEV, 8'h00), 8'hFF, 8'h00};
      tbl[15] = '{1'b1, ra(DEV, 8'h00), 8'h00, 8'h03};
      tbl[16] = '{1'b0, ra(DEV, 8'h00), 8'h00, 8'h00};
      tbl[17] = '{1'b1, {DEV, 8'h01, 8'h03}, 8'h00, 8'h00};
      tbl[18] = '{1'b0, ra(DEV, 8'h01), 8'h5A, 8'h00};
      tbl[19] = '{1'b0, ra(DEV, 8'h02), 8'hA5, 8'h00};
      tbl[20] = '{1'b1, ra(DEV, 8'h01), 8'h00, 8'h5A};
      tbl[21] = '{1'b1, ra(DEV, 8'h02), 8'h00, 8'hA5};

      // Reset values
      repeat (3) @(negedge clk_sys);
      check("rst sdata", {31'd0, sdata}, 32'd0);
      check("rst tx_vld", {31'd0, tx_vld}, 32'd0);
      check("rst tx_data", {16'd0, tx_data}, 32'd0);
      check("rst fx_q", {24'd0, fx_q}, 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk_sys);

      // Register table
      for (int i = 0; i < 22; i++) begin
         if (tbl[i].is_rd) begin
            fx_read(tbl[i].addr, q);
            check($sformatf("reg vec %0d", i), {24'd0, q}, {24'd0, tbl[i].exp});
         end else begin
            fx_write(tbl[i].addr, tbl[i].data);
         end
      end
      @(negedge clk_sys);
      check("fx_q idle", {24'd0, fx_q}, 32'd0);

      // Constant word 0xA55A
      fx_write(ra(DEV, 8'h07), 8'h01);
      xfer(16, rx, dv);
      check("const rx", rx, 32'h0000A55A);
      check("const vld", dv, 1);
      check("const tx_data", {16'd0, last_tx}, 32'h0000A55A);
      fx_read(ra(DEV, 8'h04), q);
      check("const fcnt lo", {24'd0, q}, 32'h1);

      // Ramp across the 16-bit wrap
      fx_write(ra(DEV, 8'h01), 8'hFE);
      fx_write(ra(DEV, 8'h02), 8'hFF);
      fx_write(ra(DEV, 8'h03), 8'h01);
      fx_write(ra(DEV, 8'h00), 8'h01);
      xfer(16, rx, dv); check("ramp w0", rx, 32'h0000FFFE);
      xfer(16, rx, dv); check("ramp w1", rx, 32'h0000FFFF);
      xfer(16, rx, dv); check("ramp w2", rx, 32'h00000000);
      check("ramp w2 vld", dv, 1);

      // LFSR with zero CONST uses the default seed
      fx_write(ra(DEV, 8'h00), 8'h00);
      fx_write(ra(DEV, 8'h01), 8'h00);
      fx_write(ra(DEV, 8'h02), 8'h00);
      fx_write(ra(DEV, 8'h00), 8'h02);
      xfer(16, rx, dv); check("lfsr w0", rx, 32'h0000ACE1);
      xfer(16, rx, dv); check("lfsr w1", rx, 32'h000059C3);

      // Abort after 9 rising edges, then full frames
      fx_write(ra(DEV, 8'h00), 8'h00);
      fx_write(ra(DEV, 8'h01), 8'h10);
      fx_write(ra(DEV, 8'h03), 8'h04);
      fx_write(ra(DEV, 8'h00), 8'h01);
      fx_write(ra(DEV, 8'h07), 8'h01);
      xfer(9, rx, dv);
      check("abort vld", dv, 0);
      fx_read(ra(DEV, 8'h06), q);
      check("abort cnt", {24'd0, q}, 32'h1);
      xfer(16, rx, dv); check("post-abort w0", rx, 32'h00000010);
      xfer(16, rx, dv); check("post-abort w1", rx, 32'h00000014);
      fx_read(ra(DEV, 8'h04), q);
      check("post-abort fcnt", {24'd0, q}, 32'h2);

      // Counter clear
      fx_write(ra(DEV, 8'h07), 8'h01);
      fx_read(ra(DEV, 8'h04), q); check("clr fcnt lo", {24'd0, q}, 32'h0);
      fx_read(ra(DEV, 8'h05), q); check("clr fcnt hi", {24'd0, q}, 32'h0);
      fx_read(ra(DEV, 8'h06), q); check("clr acnt", {24'd0, q}, 32'h0);

      // Reset in the middle of a frame of ones
      fx_write(ra(DEV, 8'h00), 8'h00);
      fx_write(ra(DEV, 8'h01), 8'hFF);
      fx_write(ra(DEV, 8'h02), 8'hFF);
      @(negedge clk_sys);
      cs_n = 1'b0;
      repeat (6) @(negedge clk_sys);
      for (int i = 0; i < 7; i++) begin
         sclk = 1'b1; repeat (5) @(negedge clk_sys);
         sclk = 1'b0; repeat (5) @(negedge clk_sys);
      end
      check("pre-rst sdata", {31'd0, sdata}, 32'd1);
      dv = vld_cnt;
      rst_n = 1'b0;
      @(negedge clk_sys);
      check("mid-rst sdata", {31'd0, sdata}, 32'd0);
      cs_n = 1'b1;
      repeat (4) @(negedge clk_sys);
      rst_n = 1'b1;
      model_reset();
      repeat (4) @(negedge clk_sys);
      check("mid-rst no vld", vld_cnt - dv, 0);
      fx_read(ra(DEV, 8'h04), q);
      check("mid-rst fcnt", {24'd0, q}, 32'h0);
      fx_write(ra(DEV, 8'h01), 8'h34);
      fx_write(ra(DEV, 8'h02), 8'h12);
      xfer(16, rx, dv);
      check("after-rst rx", rx, 32'h00001234);
      check("after-rst vld", dv, 1);

      // Randomised frames against the model
      for (int it = 0; it < 24; it++) begin
         if ($urandom_range(0, 9) < 3) fx_write(ra(DEV, 8'h01), 8'($urandom));
         if ($urandom_range(0, 9) < 3) fx_write(ra(DEV, 8'h02), 8'($urandom));
         if ($urandom_range(0, 9) < 3) fx_write(ra(DEV, 8'h03), 8'($urandom));
         if ($urandom_range(0, 9) < 3) fx_write(ra(DEV, 8'h00), 8'($urandom_range(0, 3)));
         nb = $urandom_range(0, 9);
         if (nb < 2)       nb = $urandom_range(1, 15);
         else if (nb == 2) nb = $urandom_range(17, 19);
         else              nb = 16;
         ew = model_word();
         xfer(nb, rx, dv);
         if (nb >= 16) begin
            check($sformatf("rnd %0d rx", it), rx, {16'd0, ew} << (nb - 16));
            check($sformatf("rnd %0d vld", it), dv, 1);
            check($sformatf("rnd %0d tx", it), {16'd0, last_tx}, {16'd0, ew});
         end else begin
            check($sformatf("rnd %0d rx", it), rx, {16'd0, ew} >> (16 - nb));
            check($sformatf("rnd %0d vld", it), dv, 0);
         end
      end
      fx_read(ra(DEV, 8'h04), q); check("rnd fcnt lo", {24'd0, q}, {24'd0, m_fcnt[7:0]});
      fx_read(ra(DEV, 8'h05), q); check("rnd fcnt hi", {24'd0, q}, {24'd0, m_fcnt[15:8]});
      fx_read(ra(DEV, 8'h06), q); check("rnd acnt", {24'd0, q}, {24'd0, m_acnt});

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
